ysyx_22050518_mul_seq: RTL and testbench

//  Iterative radix-2 shift-add multiplier for RV64M: MUL, MULH, MULHSU, MULHU, MULW.

---
 rtl/ysyx_22050518_mul_pkg.sv | 30 +++
 rtl/ysyx_22050518_add.sv | 20 ++
 rtl/ysyx_22050518_mul_seq.sv | 166 ++++++++++++++++
 tb/tb_ysyx_22050518_mul_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050518_mul_pkg.sv
// Shared constants and helpers for the iterative RV64M multiplier.
package ysyx_22050518_mul_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ITER_D = 64;
    localparam int unsigned ITER_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Two's-complement magnitude; 0x8000.. maps to 2^63, which still fits unsigned.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [XLEN-1:0] sel_result(input logic [2*XLEN-1:0] p,
                                                   input logic hi, input logic word);
        logic [XLEN-1:0] r;
        if (word)
            r = {{32{p[63]}}, p[63:32]};
        else if (hi)
            r = p[2*XLEN-1:XLEN];
        else
            r = p[XLEN-1:0];
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050518_add.sv
// Plain 64-bit adder with carry in/out, shared between the CALC step and the FIX negate.
module ysyx_22050518_add
    import ysyx_22050518_mul_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            cin_i,
    output logic [XLEN-1:0] sum_o,
    output logic            cout_o
);

    logic [XLEN:0] full;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{XLEN{1'b0}}, cin_i};
        sum_o  = full[XLEN-1:0];
        cout_o = full[XLEN];
    end

endmodule

// File: rtl/ysyx_22050518_mul_seq.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW, one op in flight.
module ysyx_22050518_mul_seq
    import ysyx_22050518_mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            mul_hi,
    input  logic            mul_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic              neg_q, neg_d;
    logic              hi_q, hi_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic              neg_in;
    logic              accept;
    logic [5:0]        last_cnt;

    logic [XLEN-1:0]   lo_a, lo_b, lo_sum, hi_sum;
    logic              lo_cin, lo_cout, hi_cout;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign last_cnt  = word_q ? 6'(ITER_W - 1) : 6'(ITER_D - 1);

    always_comb begin
        if (mul_word) begin
            a_mag_in = {32'b0, src1[31:0]};
            b_mag_in = {32'b0, src2[31:0]};
            neg_in   = 1'b0;
        end else begin
            a_mag_in = mag(src1, a_signed);
            b_mag_in = mag(src2, b_signed);
            neg_in   = (a_signed & src1[XLEN-1]) ^ (b_signed & src2[XLEN-1]);
        end
    end

    // The low adder does the partial-product add in CALC and ~P_lo+1 in FIX;
    // the high adder only matters in FIX, where it absorbs the low carry-out.
    always_comb begin
        lo_a   = p_q[2*XLEN-1:XLEN];
        lo_b   = p_q[0] ? a_mag_q : '0;
        lo_cin = 1'b0;
        if (state_q == S_FIX) begin
            lo_a   = ~p_q[XLEN-1:0];
            lo_b   = '0;
            lo_cin = 1'b1;
        end
    end

    ysyx_22050518_add u_add_lo (
        .a_i    (lo_a),
        .b_i    (lo_b),
        .cin_i  (lo_cin),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    ysyx_22050518_add u_add_hi (
        .a_i    (~p_q[2*XLEN-1:XLEN]),
        .b_i    ('0),
        .cin_i  (lo_cout),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        a_mag_d     = a_mag_q;
        neg_d       = neg_q;
        hi_d        = hi_q;
        word_d      = word_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_mag_d = a_mag_in;
                    neg_d   = neg_in;
                    hi_d    = mul_hi;
                    word_d  = mul_word;
                    cnt_d   = '0;
                    p_d     = {{XLEN{1'b0}}, b_mag_in};
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                p_d   = {lo_cout, lo_sum, p_q[XLEN-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == last_cnt)
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (neg_q)
                    p_d = {hi_sum, lo_sum};
                state_d = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle registers the result; out_valid follows from it.
                if (!out_valid_q) begin
                    result_d    = sel_result(p_q, hi_q, word_q);
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            a_mag_q     <= '0;
            neg_q       <= 1'b0;
            hi_q        <= 1'b0;
            word_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            a_mag_q     <= a_mag_d;
            neg_q       <= neg_d;
            hi_q        <= hi_d;
            word_q      <= word_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    logic unused_ok;
    assign unused_ok = hi_cout;

endmodule

// File: tb/tb_ysyx_22050518_mul_seq.sv
// Directed self-checking bench for the iterative RV64M multiplier.
module tb_ysyx_22050518_mul_seq;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [63:0] src1, src2, result;
    logic        a_signed, b_signed, mul_hi, mul_word;
    logic        out_valid, out_ready;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;

    always #5 clk = ~clk;

    ysyx_22050518_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .mul_hi    (mul_hi),
        .mul_word  (mul_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge; returns once it has been sampled.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic as, input logic bs, input logic hi, input logic w);
        src1 = a; src2 = b; a_signed = as; b_signed = bs; mul_hi = hi; mul_word = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        src1 = 64'hDEAD_BEEF_DEAD_BEEF; src2 = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Count edges after accept until out_valid; flags any in_ready while busy.
    task automatic wait_valid(output int cyc, output logic busy_rdy);
        cyc = 0;
        busy_rdy = 1'b0;
        while (cyc < 200) begin
            step();
            cyc++;
            if (out_valid) break;
            if (in_ready) busy_rdy = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic as, input logic bs, input logic hi, input logic w,
                          input logic [63:0] exp, input int exp_lat);
        int   cyc;
        logic busy_rdy;
        chk({tag, "_rdy_before"}, 64'(in_ready), 64'd1);
        issue(a, b, as, bs, hi, w);
        wait_valid(cyc, busy_rdy);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busy_rdy"}, 64'(busy_rdy), 64'd0);
        chk({tag, "_result"}, result, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int   cyc;
        logic busy_rdy;
        logic seen;
        logic [63:0] held;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; a_signed = 1'b0; b_signed = 1'b0; mul_hi = 1'b0; mul_word = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        step();

        run_op("mul_3x5", 64'd3, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, 64'd15, 66);
        run_op("mulhu_ff", '1, '1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh_ff", '1, '1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 66);
        run_op("mulh_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               1'b1, 1'b1, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 66);
        run_op("mulhsu_m1x2", '1, 64'd2, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("mulw", 64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002,
               1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("mul_neg", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF1, 66);

        // Backpressure: hold out_ready low for 10 cycles after out_valid.
        issue(64'h1234, 64'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc, busy_rdy);
        chk("bp_latency", 64'(cyc), 64'd66);
        held = result;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (!out_valid || in_ready || result !== 64'h12340) seen = 1'b1;
        end
        chk("bp_result", held, 64'h12340);
        chk("bp_stable", 64'(seen), 64'd0);
        src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_rdy_after_hs", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", 64'(in_ready), 64'd0);
        wait_valid(cyc, busy_rdy);
        chk("bp_next_result", result, 64'd81);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush on the same edge as a request: request must be dropped.
        src1 = 64'd2; src2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_drops_accept", 64'(in_ready), 64'd1);

        // Flush mid-CALC.
        issue(64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (19) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // Reset mid-CALC, then a fresh op.
        issue(64'd11, 64'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (39) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_result", result, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_valid", 64'(seen), 64'd0);
        run_op("mul_7x6", 64'd7, 64'd6, 1'b1, 1'b1, 1'b0, 1'b0, 64'd42, 66);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
